// File: rtl/verilab_i2c_gpio_target.sv
// I2C target exposing a small GPIO register file (out, oe, in, zero) behind a 2-bit pointer.
// Define VERILAB_I2C_GPIO_TARGET_AUTOINC_EN to advance the pointer after every data byte.
module verilab_i2c_gpio_target #(
    parameter logic [6:0]  ADDR = 7'h48,
    parameter int unsigned GPIO = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scl_in,
    input  logic            sda_in,
    output logic            sda_oe,
    input  logic [GPIO-1:0] gpio_in,
    output logic [GPIO-1:0] gpio_out,
    output logic [GPIO-1:0] gpio_oe,
    output logic            busy
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck, StRdata, StRack
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        scl_sync_q, sda_sync_q;
    logic [GPIO-1:0]   gin_meta_q, gin_q;
    logic              scl_prev_q, sda_prev_q;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d, rdata_q, rdata_d, rd_val, wbyte;
    logic [1:0]        ptr_q, ptr_d;
    logic              sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic [GPIO-1:0]   gpio_out_q, gpio_out_d, gpio_oe_q, gpio_oe_d;
    logic              sscl, ssda, scl_rise, scl_fall, start_det, stop_det, byte_done, ack_done;

    assign sscl      = scl_sync_q[1];
    assign ssda      = sda_sync_q[1];
    assign scl_rise  = sscl & ~scl_prev_q;
    assign scl_fall  = ~sscl & scl_prev_q;
    assign start_det = sscl & scl_prev_q & sda_prev_q & ~ssda;
    assign stop_det  = sscl & scl_prev_q & ~sda_prev_q & ssda;
    assign byte_done = (cnt_q == 4'd8);
    assign ack_done  = (cnt_q != 4'd0);
    assign wbyte     = {shift_q[6:0], ssda};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            gin_meta_q <= '1;
            gin_q      <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            gin_meta_q <= gpio_in;
            gin_q      <= gin_meta_q;
            scl_prev_q <= sscl;
            sda_prev_q <= ssda;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Bits are captured on SCL rise; every state change lands on an SCL fall.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = StAddr;
        end else if (stop_det) begin
            state_d = StIdle;
        end else if (scl_fall) begin
            unique case (state_q)
                StAddr:     if (byte_done) state_d = (shift_q[7:1] == ADDR) ? StAddrAck : StIdle;
                StAddrAck:  if (ack_done)  state_d = shift_q[0] ? StRdata : StPtr;
                StPtr:      if (byte_done) state_d = StPtrAck;
                StPtrAck:   if (ack_done)  state_d = StWdata;
                StWdata:    if (byte_done) state_d = StWdataAck;
                StWdataAck: if (ack_done)  state_d = StWdata;
                StRdata:    if (byte_done) state_d = StRack;
                StRack:     if (ack_done)  state_d = shift_q[0] ? StIdle : StRdata;
                default:    state_d = state_q;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        unique case (ptr_q)
            2'd0:    rd_val[GPIO-1:0] = gpio_out_q;
            2'd1:    rd_val[GPIO-1:0] = gpio_oe_q;
            2'd2:    rd_val[GPIO-1:0] = gin_q;
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rdata_d    = rdata_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        gpio_out_d = gpio_out_q;
        gpio_oe_d  = gpio_oe_q;
        if (start_det || stop_det) begin
            // Any partial byte is dropped simply by clearing the counter.
            busy_d   = start_det;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else begin
            if (scl_rise && state_q != StIdle) begin
                cnt_d = cnt_q + 4'd1;
                if (state_q inside {StAddr, StPtr, StWdata, StRack}) shift_d = wbyte;
                if (state_q == StPtr && cnt_q == 4'd7) ptr_d = wbyte[1:0];
                if (state_q == StWdata && cnt_q == 4'd7) begin
                    if (ptr_q == 2'd0) gpio_out_d = wbyte[GPIO-1:0];
                    if (ptr_q == 2'd1) gpio_oe_d  = wbyte[GPIO-1:0];
`ifdef VERILAB_I2C_GPIO_TARGET_AUTOINC_EN
                    ptr_d = ptr_q + 2'd1;
`endif
                end
            end
            if (scl_fall && state_d != state_q) begin
                cnt_d = '0;
                unique case (state_d)
                    StAddrAck, StPtrAck, StWdataAck: sda_oe_d = 1'b1;
                    StRdata: begin
                        rdata_d  = rd_val;
                        sda_oe_d = ~rd_val[7];
                    end
                    StRack: begin
                        sda_oe_d = 1'b0;
`ifdef VERILAB_I2C_GPIO_TARGET_AUTOINC_EN
                        ptr_d = ptr_q + 2'd1;
`endif
                    end
                    default: sda_oe_d = 1'b0;
                endcase
            end else if (scl_fall && state_q == StRdata && cnt_q != 4'd0) begin
                sda_oe_d = ~rdata_q[3'(4'd7 - cnt_q)];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            rdata_q    <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            gpio_out_q <= '0;
            gpio_oe_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rdata_q    <= rdata_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            gpio_out_q <= gpio_out_d;
            gpio_oe_q  <= gpio_oe_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign gpio_out = gpio_out_q;
    assign gpio_oe  = gpio_oe_q;

endmodule

// File: doc/verilab_i2c_gpio_target.md
VERILAB_I2C_GPIO_TARGET -- requirements
Module: verilab_i2c_gpio_target

Interface
REQ-001 The block SHALL have parameter ADDR, default 7'h48, meaning the 7-bit I2C target address.
REQ-002 The block SHALL have parameter GPIO, default 8, meaning the GPIO width (legal 1..8).
REQ-003 Port clk  input  1  system clock; the block SHALL use a single clock.
REQ-004 Port reset  input  1  reset, asynchronous and active-high.
REQ-005 Port scl_in  input  1  raw I2C SCL pad level (asynchronous).
REQ-006 Port sda_in  input  1  raw I2C SDA pad level (asynchronous).
REQ-007 Port sda_oe  output  1  1 = pad drives SDA low; 0 = released.
REQ-008 Port gpio_in  input  GPIO  pad levels, asynchronous.
REQ-009 Port gpio_out  output  GPIO  output-data register.
REQ-010 Port gpio_oe  output  GPIO  output-enable register, 1 = drive.
REQ-011 Port busy  output  1  high from START detect until STOP detect.

Function
REQ-012 scl_in, sda_in and gpio_in SHALL each pass through a 2-flop synchronizer; all logic SHALL use the synchronized values (sscl, ssda).
REQ-013 START SHALL be detected on an ssda 1->0 transition while sscl=1; STOP on ssda 0->1 while sscl=1; repeated START SHALL be accepted in any state.
REQ-014 Bits SHALL be sampled on sscl rise; sda_oe SHALL change only on the clk after an sscl fall.
REQ-015 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK; START -> ADDR from any state; STOP -> IDLE from any state.
REQ-016 ADDR: shift 8 bits MSB first; on a match with ADDR go to ADDR_ACK, else go to IDLE with sda_oe=0 until the next START.
REQ-017 ADDR_ACK: sda_oe=1 for the 9th SCL pulse; then R/W=0 -> PTR, R/W=1 -> RDATA.
REQ-018 PTR: byte[1:0] loads the pointer; ACK, then WDATA. Registers: 0 gpio_out (RW), 1 gpio_oe (RW), 2 gpio_in (RO), 3 reads 0.
REQ-019 WDATA: after the 8th bit, write byte[GPIO-1:0] to the pointed register (writes to 2/3 ignored), ACK all bytes, then return to WDATA.
REQ-020 RDATA: latch the pointed register (zero-extended) at state entry; drive sda_oe = ~bit MSB first; then RACK.
REQ-021 RACK: release SDA; master ACK(0) -> RDATA with the next byte, NACK(1) -> IDLE (SDA released until STOP/START).
REQ-022 The register update SHALL be visible on gpio_out/gpio_oe on the clk after the 8th-bit sscl rise.
REQ-023 A START or STOP mid-byte SHALL discard the partial byte with no register write.

Reset
REQ-024 While reset=1: FSM=IDLE, sda_oe=0, busy=0, gpio_out=0, gpio_oe=0, pointer=0, shift counters=0, synchronizer flops=1.
REQ-025 Reset assertion mid-transfer SHALL release SDA immediately (asynchronously), with no partial write.

Configuration
REQ-026 Macro VERILAB_I2C_GPIO_TARGET_AUTOINC_EN defined: the pointer SHALL increment after each data byte (write or read), wrapping 3->0; undefined: the pointer SHALL hold its value across bytes.

Verification
REQ-027 Write 0x90,0x00,0xA5 then STOP, GPIO=8 -> three ACKs, gpio_out=8'hA5, gpio_oe=0, busy low after STOP.
REQ-028 gpio_in=8'h3C; write 0x90,0x02; repeated START; 0x91; read one byte with NACK -> SDA shows 0x3C, FSM=IDLE, sda_oe=0.
REQ-029 Address 0x92 (no match) -> no ACK on the 9th bit, sda_oe=0 throughout, registers unchanged.
REQ-030 AUTOINC_EN defined: write 0x90,0x00,0x11,0xFF -> gpio_out=8'h11, gpio_oe=8'hFF; undefined -> gpio_out=8'hFF, gpio_oe=0.
REQ-031 STOP after 4 bits of a data byte -> no register write, FSM=IDLE.
REQ-032 reset pulsed during the ACK of a data byte -> sda_oe=0 within the reset, all registers=0.
